sm_clk_ctrl: RTL and testbench

//   Parametrised successor to the tunable clock divider. Generates the CPU clock from clkIn

---
 rtl/sm_clk_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sm_clk_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_clk_ctrl.sv
// -----------------------------------------------------------------------------
// sm_clk_ctrl
//
// Generates the CPU clock from the system clock. It has three modes: free-run,
// single-step from a debounced button, and hold. Every high phase and every low
// phase lasts exactly H = 2^(SHIFT+div_cur) system cycles. A new period select
// takes effect only when a period starts, so a phase is never shortened or
// stretched. The block also provides a one-cycle tick on each rising edge of
// o_clk_out and a wrapping count of those rising edges.
//
// Parameters
//   SHIFT       base exponent of the half period
//   DIV_W       width of the period select
//   CNT_W       width of the rising-edge counter
//   DEB_CYCLES  consecutive stable samples needed to accept a new button level
//
// Ports
//   i_clk_in        system clock; all logic runs on its rising edge
//   i_rst           synchronous reset, active-high
//   i_enable        0 freezes the period counter and o_clk_out in place
//   i_mode          2'b00 run, 2'b01 step, 2'b1x hold
//   i_devide        period select, sampled only when a period starts
//   i_step_btn      raw asynchronous step button
//   o_clk_out       generated clock, 50% duty
//   o_clk_tick      1 in the cycle where o_clk_out goes 0->1
//   o_busy          1 while a period is in progress (not parked)
//   o_div_cur       period select in effect for the current period
//   o_cycle_count   number of o_clk_out rising edges since reset, wraps
// -----------------------------------------------------------------------------
module sm_clk_ctrl #(
  parameter int unsigned SHIFT      = 12,
  parameter int unsigned DIV_W      = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             i_clk_in,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic [DIV_W-1:0] i_devide,
  input  logic             i_step_btn,
  output logic             o_clk_out,
  output logic             o_clk_tick,
  output logic             o_busy,
  output logic [DIV_W-1:0] o_div_cur,
  output logic [CNT_W-1:0] o_cycle_count
);

  // The phase counter is just wide enough to hold H-1 for the largest select.
  localparam int unsigned CTR_W     = SHIFT + (1 << DIV_W) - 1;
  localparam int unsigned DEB_W     = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_ONES = '1;

  // Bit 0 of the state is the generated clock itself, so o_clk_out comes
  // straight from a flop and cannot glitch.
  localparam logic [1:0] ST_PARK = 2'b00;
  localparam logic [1:0] ST_HIGH = 2'b01;
  localparam logic [1:0] ST_LOW  = 2'b10;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;

  // ---------------------------------------------------------------------------
  // Step button: two-flop synchroniser followed by a debounce counter
  // ---------------------------------------------------------------------------
  logic             r_sync1;
  logic             r_sync2;
  logic             r_step_clean;
  logic             r_step_clean_d;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             w_step_edge;

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_sync1        <= 1'b0;
      r_sync2        <= 1'b0;
      r_step_clean   <= 1'b0;
      r_step_clean_d <= 1'b0;
      r_deb_cnt      <= '0;
    end else begin
      r_sync1        <= i_step_btn;
      r_sync2        <= r_sync1;
      r_step_clean_d <= r_step_clean;
      if (r_sync2 == r_step_clean) begin
        // Any sample that agrees with the accepted level restarts the count.
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_step_clean <= ~r_step_clean;
        r_deb_cnt    <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_step_edge = r_step_clean & ~r_step_clean_d;

  // ---------------------------------------------------------------------------
  // Period generator
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [CTR_W-1:0] r_ctr;
  logic             r_tick;
  logic [DIV_W-1:0] r_div_cur;
  logic [CNT_W-1:0] r_cycle_count;

  logic [1:0]       w_state_d;
  logic [CTR_W-1:0] w_ctr_d;
  logic             w_tick_d;
  logic [DIV_W-1:0] w_div_d;
  logic [CNT_W-1:0] w_cycle_count_d;
  logic             w_start;
  logic             w_ctr_zero;
  logic             w_mode_run;
  logic             w_mode_step;
  logic [CTR_W-1:0] w_half_new;
  logic [CTR_W-1:0] w_half_cur;

  assign w_ctr_zero  = (r_ctr == '0);
  assign w_mode_run  = (i_mode == MODE_RUN);
  assign w_mode_step = (i_mode == MODE_STEP);

  // H-1 = 2^(SHIFT+d)-1 is an all-ones mask. Shifting the full-width mask
  // right by (2^DIV_W-1-d), which equals ~d, produces it without a multiplier.
  assign w_half_new = CTR_ONES >> (~i_devide);
  assign w_half_cur = CTR_ONES >> (~r_div_cur);

  always_comb begin
    w_state_d       = r_state;
    w_ctr_d         = r_ctr;
    w_tick_d        = 1'b0;
    w_div_d         = r_div_cur;
    w_cycle_count_d = r_cycle_count;
    w_start         = 1'b0;

    // When i_enable is low, nothing advances. A step edge that arrives in
    // that cycle is dropped because it is never looked at.
    if (i_enable) begin
      case (r_state)
        ST_HIGH: begin
          // The mode is ignored here. Once a period starts, it always completes.
          if (w_ctr_zero) begin
            w_state_d = ST_LOW;
            w_ctr_d   = w_half_cur;
          end else begin
            w_ctr_d = r_ctr - 1'b1;
          end
        end
        ST_LOW: begin
          if (w_ctr_zero) begin
            // End of a period: this is the only point where the mode matters
            // for a running clock.
            if (w_mode_run) begin
              w_start = 1'b1;
            end else begin
              w_state_d = ST_PARK;
            end
          end else begin
            w_ctr_d = r_ctr - 1'b1;
          end
        end
        ST_PARK: begin
          if (w_mode_run || (w_mode_step && w_step_edge)) begin
            w_start = 1'b1;
          end
        end
        default: begin
          w_state_d = ST_PARK;
          w_ctr_d   = '0;
        end
      endcase

      if (w_start) begin
        w_state_d       = ST_HIGH;
        w_ctr_d         = w_half_new;
        w_tick_d        = 1'b1;
        w_div_d         = i_devide;
        w_cycle_count_d = r_cycle_count + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state       <= ST_PARK;
      r_ctr         <= '0;
      r_tick        <= 1'b0;
      r_div_cur     <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_d;
      r_ctr         <= w_ctr_d;
      r_tick        <= w_tick_d;
      r_div_cur     <= w_div_d;
      r_cycle_count <= w_cycle_count_d;
    end
  end

  assign o_clk_out     = r_state[0];
  assign o_clk_tick    = r_tick;
  assign o_busy        = (r_state != ST_PARK);
  assign o_div_cur     = r_div_cur;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sm_clk_ctrl
//
// Directed bench for sm_clk_ctrl with SHIFT=2, DIV_W=4, CNT_W=3 and DEB_CYCLES=3.
// The stimulus process pushes the expected o_clk_out edges into a queue. For
// each edge it records the cycle, and for each rise it also records the
// expected div_cur and cycle_count. A monitor samples the outputs 1 time unit
// after each rising edge of the system clock. On every edge of o_clk_out it pops
// the queue and compares.
// The cycle counter cyc is the number of system-clock rising edges seen so far.
// -----------------------------------------------------------------------------
module tb_sm_clk_ctrl;

  localparam int unsigned SHIFT = 2;
  localparam int unsigned DIV_W = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DEB   = 3;
  localparam int B = 3;  // last cycle held in reset

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic [DIV_W-1:0] devide = '0;
  logic             step_btn = 1'b0;
  logic             clk_out;
  logic             clk_tick;
  logic             busy;
  logic [DIV_W-1:0] div_cur;
  logic [CNT_W-1:0] cycle_count;

  sm_clk_ctrl #(
    .SHIFT(SHIFT),
    .DIV_W(DIV_W),
    .CNT_W(CNT_W),
    .DEB_CYCLES(DEB)
  ) dut (
    .i_clk_in(clk),
    .i_rst(rst),
    .i_enable(enable),
    .i_mode(mode),
    .i_devide(devide),
    .i_step_btn(step_btn),
    .o_clk_out(clk_out),
    .o_clk_tick(clk_tick),
    .o_busy(busy),
    .o_div_cur(div_cur),
    .o_cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rise;
    int cyc;
    int div;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_rise(input int c, input int d, input int n);
    exp_t e;
    e.rise = 1'b1;
    e.cyc  = c;
    e.div  = d;
    e.cnt  = n;
    sb.push_back(e);
  endtask

  task automatic push_fall(input int c);
    exp_t e;
    e.rise = 1'b0;
    e.cyc  = c;
    e.div  = 0;
    e.cnt  = 0;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: detects o_clk_out edges and checks them against the scoreboard.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (clk_out != prev) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_edge: clk_out became %0b at cycle %0d, none expected",
                   clk_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("edge_kind", clk_out, e.rise);
          chk("edge_cycle", cyc, e.cyc);
          if (e.rise) begin
            chk("tick_on_rise", clk_tick, 1);
            chk("div_cur", div_cur, e.div);
            chk("cycle_count", cycle_count, e.cnt);
          end else begin
            chk("tick_on_fall", clk_tick, 0);
          end
        end
      end else begin
        chk("tick_idle", clk_tick, 0);
      end
      prev = clk_out;
    end
  end

  initial begin : watchdog
    #5000;
    $display("FAIL timeout: run did not end, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset state
    wait_until(B);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", clk_tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_cur", div_cur, 0);
    chk("rst_count", cycle_count, 0);
    rst = 1'b0;

    // Run mode, H=4: the first rise comes on the first edge after reset is released.
    push_rise(B + 1, 0, 1);  push_fall(B + 5);
    push_rise(B + 9, 0, 2);  push_fall(B + 13);
    push_rise(B + 17, 0, 3); push_fall(B + 21);

    // Change devide to 2 during a high phase: the period in progress stays 4/4, the next is 16/16.
    wait_until(B + 18);
    devide = 4'd2;
    push_rise(B + 25, 2, 4); push_fall(B + 41);

    // Change devide back to 0 during the 16-cycle high phase: that period is unaffected.
    wait_until(B + 26);
    devide = 4'd0;
    chk("busy_in_period", busy, 1);
    push_rise(B + 57, 0, 5); push_fall(B + 61);

    // Switch to hold mid-low: the low phase completes, then the clock parks.
    wait_until(B + 62);
    mode = 2'b10;
    wait_until(B + 64);
    chk("busy_end_of_low", busy, 1);
    wait_until(B + 66);
    chk("hold_busy", busy, 0);
    chk("hold_clk_out", clk_out, 0);
    wait_until(B + 68);
    mode = 2'b00;
    // The high phase includes 5 frozen cycles: 4 enabled cycles + 5 frozen, so the fall is at B+78.
    push_rise(B + 69, 0, 6); push_fall(B + 78);

    wait_until(B + 70);
    enable = 1'b0;
    wait_until(B + 73);
    chk("frozen_clk_out", clk_out, 1);
    chk("frozen_busy", busy, 1);
    wait_until(B + 75);
    enable = 1'b1;
    push_rise(B + 82, 0, 7);

    // Reset mid-high with cycle_count=7. Step mode and devide=2 are set for the next test.
    wait_until(B + 83);
    chk("pre_rst_count", cycle_count, 7);
    chk("pre_rst_clk_out", clk_out, 1);
    rst    = 1'b1;
    mode   = 2'b01;
    devide = 4'd2;
    push_fall(B + 84);
    wait_until(B + 84);
    rst = 1'b0;
    chk("mid_rst_clk_out", clk_out, 0);
    chk("mid_rst_count", cycle_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_div_cur", div_cur, 0);

    // Step: the button bounces 1-0-1 and then holds. After the 2-flop
    // synchroniser and 3 stable samples, the clean level rises at B+92 and the
    // period starts at B+93.
    wait_until(B + 85);
    step_btn = 1'b1;
    wait_until(B + 86);
    step_btn = 1'b0;
    wait_until(B + 87);
    step_btn = 1'b1;
    push_rise(B + 93, 2, 1); push_fall(B + 109);

    // Release, then press again. The second edge reaches the generator at B+104, while busy.
    wait_until(B + 93);
    step_btn = 1'b0;
    wait_until(B + 98);
    step_btn = 1'b1;
    wait_until(B + 104);
    chk("step_busy", busy, 1);
    wait_until(B + 126);
    chk("step_parked_busy", busy, 0);
    chk("step_parked_clk", clk_out, 0);

    // Run mode again with H=4. The 8th rise since reset makes cycle_count wrap to 0.
    wait_until(B + 130);
    mode   = 2'b00;
    devide = 4'd0;
    for (int k = 0; k < 7; k++) begin
      push_rise(B + 131 + 8 * k, 0, (2 + k) % 8);
      push_fall(B + 135 + 8 * k);
    end
    wait_until(B + 180);
    mode = 2'b10;

    wait_until(B + 195);
    chk("final_busy", busy, 0);
    chk("final_count", cycle_count, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
